// File: rtl/rst_seq_pkg.sv
// Shared encodings for the reset sequencer: reset-cause codes and FSM states.
package rst_seq_pkg;

    typedef enum logic [1:0] {
        CAUSE_POR = 2'd0,
        CAUSE_KEY = 2'd1,
        CAUSE_SW  = 2'd2,
        CAUSE_WDT = 2'd3
    } cause_e;

    typedef enum logic [1:0] {
        ST_ASSERT  = 2'd0,
        ST_HOLD    = 2'd1,
        ST_RELEASE = 2'd2,
        ST_RUN     = 2'd3
    } state_e;

endpackage

// File: rtl/rst_seq_debounce.sv
// Synchronizer plus debouncer for a slow, bouncy input; reports the accepted
// level and a one-cycle pulse when the accepted level falls.
module rst_seq_debounce #(
    parameter int   SYNC_STAGES  = 2,
    parameter int   DEBOUNCE_CNT = 1000,
    parameter int   CNT_W        = 16,
    parameter logic IDLE_LEVEL   = 1'b1
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic raw,
    output logic level,
    output logic fall
);

    localparam logic [CNT_W-1:0] DEB_LIM = CNT_W'(DEBOUNCE_CNT - 1);

    logic [SYNC_STAGES-1:0] sync;
    logic [CNT_W-1:0]       cnt;
    logic                   synced;

    assign synced = sync[SYNC_STAGES-1];

    // The chain resets to the idle level so a reset can never be seen as a press.
    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sync  <= {SYNC_STAGES{IDLE_LEVEL}};
            cnt   <= '0;
            level <= IDLE_LEVEL;
            fall  <= 1'b0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], raw};
            fall <= 1'b0;
            if (synced == level) begin
                cnt <= '0;
            end else if (cnt == DEB_LIM) begin
                cnt   <= '0;
                level <= synced;
                fall  <= ~synced;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/rst_seq_ctrl.sv
// Reset sequencer: merges POR, push-button and software reset into ordered
// active-high resets. Optional watchdog source enabled by RST_SEQ_WDT_EN.
module rst_seq_ctrl
    import rst_seq_pkg::*;
#(
    parameter int SYNC_STAGES  = 2,
    parameter int NUM_RST      = 4,
    parameter int HOLD_CNT     = 50,
    parameter int STEP_CNT     = 16,
    parameter int DEBOUNCE_CNT = 1000,
    parameter int CNT_W        = 16
`ifdef RST_SEQ_WDT_EN
    ,
    parameter int WDT_TIMEOUT  = 65535
`endif
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic               key_n_i,
    input  logic               sw_rst_req_i,
`ifdef RST_SEQ_WDT_EN
    input  logic               wdt_en_i,
    input  logic               wdt_kick_i,
`endif
    output logic [NUM_RST-1:0] rst_o,
    output logic               busy_o,
    output logic [1:0]         rst_cause_o
);

    localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(HOLD_CNT);
    localparam logic [CNT_W-1:0] STEP_LIM = CNT_W'(STEP_CNT - 1);

    state_e                 state;
    logic [CNT_W-1:0]       cnt;
    logic [SYNC_STAGES-1:0] por_sync;
    logic                   por_ok;
    logic                   key_level;
    logic                   key_fall;
    logic                   hold_ok;
    logic                   sw_take;
    logic                   wdt_fire;
    logic                   advance;
    logic [NUM_RST-1:0]     rst_shift;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            por_sync <= '0;
        end else begin
            por_sync <= {por_sync[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign por_ok = por_sync[SYNC_STAGES-1];

    rst_seq_debounce #(
        .SYNC_STAGES (SYNC_STAGES),
        .DEBOUNCE_CNT(DEBOUNCE_CNT),
        .CNT_W       (CNT_W),
        .IDLE_LEVEL  (1'b1)
    ) u_key (
        .clk_i  (clk_i),
        .rst_n_i(rst_n_i),
        .raw    (key_n_i),
        .level  (key_level),
        .fall   (key_fall)
    );

`ifdef RST_SEQ_WDT_EN
    localparam logic [CNT_W-1:0] WDT_LIM = CNT_W'(WDT_TIMEOUT - 1);

    logic [CNT_W-1:0] wdt_cnt;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wdt_cnt <= '0;
        end else if (state != ST_RUN || !wdt_en_i || wdt_kick_i || wdt_fire) begin
            wdt_cnt <= '0;
        end else begin
            wdt_cnt <= wdt_cnt + 1'b1;
        end
    end

    assign wdt_fire = (state == ST_RUN) && wdt_en_i && !wdt_kick_i && (wdt_cnt == WDT_LIM);
`else
    assign wdt_fire = 1'b0;
`endif

    // Shifting left clears the lowest still-set bit, giving bit 0 first order.
    assign rst_shift = rst_o << 1;
    assign hold_ok   = key_level && por_ok;
    assign sw_take   = (state == ST_RUN) && sw_rst_req_i;
    assign advance   = (state == ST_HOLD)    ? (hold_ok && cnt == HOLD_LIM) :
                       (state == ST_RELEASE) && (cnt == STEP_LIM);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state       <= ST_ASSERT;
            cnt         <= '0;
            rst_o       <= '1;
            busy_o      <= 1'b1;
            rst_cause_o <= CAUSE_POR;
        end else if (key_fall || wdt_fire || sw_take) begin
            state       <= ST_ASSERT;
            cnt         <= '0;
            rst_o       <= '1;
            busy_o      <= 1'b1;
            rst_cause_o <= key_fall ? CAUSE_KEY : (wdt_fire ? CAUSE_WDT : CAUSE_SW);
        end else begin
            unique case (state)
                ST_ASSERT: begin
                    state  <= ST_HOLD;
                    cnt    <= '0;
                    rst_o  <= '1;
                    busy_o <= 1'b1;
                end
                ST_HOLD, ST_RELEASE: begin
                    if (advance) begin
                        cnt   <= '0;
                        rst_o <= rst_shift;
                        if (rst_shift == '0) begin
                            state  <= ST_RUN;
                            busy_o <= 1'b0;
                        end else begin
                            state <= ST_RELEASE;
                        end
                    end else if (state == ST_HOLD && !hold_ok) begin
                        cnt <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_RUN: begin
                    rst_o  <= '0;
                    busy_o <= 1'b0;
                end
            endcase
        end
    end

endmodule
